// File: rtl/seq_compare_if.sv
// Request/response bundle for seq_compare_unit.
//   start/a/b/cond/sgn : request side, driven by the requester (master)
//   busy/done/comp_out : status side, driven by the compare unit (slave)
// cond encoding: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LE, 101 GT, 110 FALSE, 111 TRUE.
// sgn=1 selects a two's-complement compare, sgn=0 an unsigned one.
interface seq_compare_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cond;
    logic             sgn;
    logic             busy;
    logic             done;
    logic             comp_out;

    modport master (
        output start, a, b, cond, sgn,
        input  busy, done, comp_out
    );

    modport slave (
        input  start, a, b, cond, sgn,
        output busy, done, comp_out
    );
endinterface

// File: rtl/seq_compare_unit.sv
// Multi-cycle set-condition compare for the DLX extended compare path.
// Scans the latched operands MSB-first, CHUNK bits per cycle, and finishes
// at the first differing chunk (or at the last chunk when all are equal).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : seq_compare_if slave (start/a/b/cond/sgn in, busy/done/comp_out out)
module seq_compare_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_compare_if.slave  bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       cond_q, cond_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             comp_q, comp_d;

    // Operands are shifted left after each non-decisive cycle, so the chunk
    // under test always sits in the top CHUNK bits.
    logic [CHUNK-1:0] chunk_a_c, chunk_b_c;
    logic             lt_c, gt_c, eq_c, last_c, result_c;

    assign chunk_a_c = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b_c = b_q[WIDTH-1 -: CHUNK];
    assign lt_c      = chunk_a_c < chunk_b_c;
    assign gt_c      = chunk_a_c > chunk_b_c;
    assign eq_c      = chunk_a_c == chunk_b_c;
    assign last_c    = idx_q == IDX_W'(NCHUNK - 1);

    // Condition decode; eq is only meaningful once every chunk has matched.
    always_comb begin
        result_c = 1'b0;
        unique case (cond_q)
            3'b000:  result_c = eq_c;
            3'b001:  result_c = !eq_c;
            3'b010:  result_c = lt_c;
            3'b011:  result_c = !lt_c;
            3'b100:  result_c = lt_c | eq_c;
            3'b101:  result_c = gt_c;
            3'b110:  result_c = 1'b0;
            default: result_c = 1'b1;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cond_d  = cond_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        comp_d  = comp_q;

        unique case (state_q)
            S_CMP: begin
                if (!eq_c || last_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    comp_d  = result_c;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    a_d    = a_q << CHUNK;
                    b_d    = b_q << CHUNK;
                    busy_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request (busy is low).
                if (bus.start) begin
                    state_d = S_CMP;
                    idx_d   = '0;
                    // Flipping the sign bits maps a signed compare onto an unsigned one.
                    a_d     = {bus.a[WIDTH-1] ^ bus.sgn, bus.a[WIDTH-2:0]};
                    b_d     = {bus.b[WIDTH-1] ^ bus.sgn, bus.b[WIDTH-2:0]};
                    cond_d  = bus.cond;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cond_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cond_q  <= cond_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            comp_q  <= comp_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.comp_out = comp_q;

endmodule

// File: tb/tb_seq_compare_unit.sv
// Self-checking bench for seq_compare_unit: directed cases with literal
// latencies/results plus randomized traffic against a behavioural model.
module tb_seq_compare_unit;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n;

    seq_compare_if #(.WIDTH(WIDTH)) bus ();

    seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Index of the first differing chunk scanning MSB-first; NCHUNK-1 if equal.
    function automatic int first_diff(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ua, ub;
        ua = s ? (a ^ 32'h8000_0000) : a;
        ub = s ? (b ^ 32'h8000_0000) : b;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (((ua >> (WIDTH - CHUNK * (i + 1))) & 32'hFF) != ((ub >> (WIDTH - CHUNK * (i + 1))) & 32'hFF))
                return i;
        end
        return int'(NCHUNK) - 1;
    endfunction

    function automatic logic eval(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] c, input logic s);
        logic lt, eq;
        eq = (a == b);
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        case (c)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd2:    return lt;
            3'd3:    return !lt;
            3'd4:    return lt || eq;
            3'd5:    return !lt && !eq;
            3'd6:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Behavioural model: an accepted request finishes after first_diff+1 edges.
    logic m_busy = 1'b0, m_done = 1'b0, m_comp = 1'b0, m_pend = 1'b0;
    int   m_rem = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_comp <= 1'b0;
            m_rem  <= 0;
        end else if (m_busy) begin
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_comp <= m_pend;
            end else begin
                m_rem  <= m_rem - 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_busy <= 1'b1;
                m_rem  <= first_diff(bus.a, bus.b, bus.sgn) + 1;
                m_pend <= eval(bus.a, bus.b, bus.cond, bus.sgn);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("comp_out", 32'(bus.comp_out), 32'(m_comp));
        end
    end

    // Called just after the accept edge; returns edges from accept to DONE.
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
            n++;
            if (n >= 30) begin
                chk("done_timeout", 32'(n), 32'd0);
                return;
            end
        end
    endtask

    task automatic do_op(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [2:0] ic, input logic is,
                         input int exp_lat, input logic exp_c);
        int n;
        bus.start = 1'b1;
        bus.a = ia; bus.b = ib; bus.cond = ic; bus.sgn = is;
        @(posedge clk);
        #1;
        // Inputs wander after acceptance; the result must not follow them.
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        bus.cond = 3'($urandom_range(0, 7)); bus.sgn = 1'($urandom_range(0, 1));
        wait_done(n);
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk({nm, "_comp"}, 32'(bus.comp_out), 32'(exp_c));
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cond = '0; bus.sgn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_comp", 32'(bus.comp_out), 32'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        do_op("eq_equal",  32'h1234_5678, 32'h1234_5678, 3'd0, 1'b0, 4, 1'b1);
        do_op("ne_equal",  32'h1234_5678, 32'h1234_5678, 3'd1, 1'b0, 4, 1'b0);
        do_op("lt_signed", 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b1, 1, 1'b1);
        do_op("lt_unsign", 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, 1, 1'b0);
        do_op("le_small",  32'h0000_0005, 32'h0000_0007, 3'd4, 1'b0, 4, 1'b1);
        do_op("gt_small",  32'h0000_0005, 32'h0000_0007, 3'd5, 1'b0, 4, 1'b0);
        do_op("ge_mid",    32'h0012_0000, 32'h0034_0000, 3'd3, 1'b0, 2, 1'b0);

        // START while busy is ignored.
        bus.start = 1'b1; bus.a = 32'h8000_0000; bus.b = '0; bus.cond = 3'd5; bus.sgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.a = '0; bus.b = 32'd1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_done", 32'(bus.done), 32'd1);
        chk("ign_comp", 32'(bus.comp_out), 32'd1);
        @(negedge clk);
        chk("ign_idle", 32'(bus.busy), 32'd0);

        // Reset mid-compare drops the operation.
        bus.start = 1'b1; bus.a = 32'hCAFE_F00D; bus.b = 32'hCAFE_F00D; bus.cond = 3'd0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_comp", 32'(bus.comp_out), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk("mrst_nodone", 32'(seen), 32'd0);

        // START held across DONE: FALSE then TRUE back to back.
        bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd2; bus.cond = 3'd6; bus.sgn = 1'b0;
        @(posedge clk);
        wait_done(n);
        chk("b2b_lat0", 32'(n), 32'd4);
        chk("b2b_comp0", 32'(bus.comp_out), 32'd0);
        bus.cond = 3'd7;
        @(posedge clk);
        wait_done(n);
        chk("b2b_lat1", 32'(n), 32'd4);
        chk("b2b_comp1", 32'(bus.comp_out), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);

        // Randomized traffic, occasional resets, model-checked every cycle.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bus.start = ($urandom_range(0, 2) != 0);
            bus.a = $urandom;
            case ($urandom_range(0, 3))
                0:       bus.b = bus.a;
                1:       bus.b = bus.a ^ (32'h1 << $urandom_range(0, 31));
                2:       bus.b = bus.a ^ (32'hFF << (8 * $urandom_range(0, 3)));
                default: bus.b = $urandom;
            endcase
            bus.cond = 3'($urandom_range(0, 7));
            bus.sgn  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst_n = 1'b1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
